// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-block, read-only instruction cache.
// Hits return data combinationally; a miss stalls fetch, reads one word
// from the memory controller and fills the indexed frame.
module icache_direct #(
    parameter int SETS  = 16,
    parameter int IDX_W = $clog2(SETS),
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    typedef enum logic {IDLE, MISS} state_e;

    state_e            state_q;
    logic [31:0]       miss_addr_q;
    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [31:0]       data_q [SETS];

    logic [IDX_W-1:0]  req_idx, miss_idx;
    logic [TAG_W-1:0]  req_tag, miss_tag;
    logic              hit;
    logic              fill;

    assign req_idx  = imemaddr[IDX_W+1:2];
    assign req_tag  = imemaddr[31:IDX_W+2];
    assign miss_idx = miss_addr_q[IDX_W+1:2];
    assign miss_tag = miss_addr_q[31:IDX_W+2];

    assign hit  = imemREN & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
    // Fill happens on the first MISS cycle where memory stops waiting.
    assign fill = (state_q == MISS) & ~iwait;

    // Fetch-side and memory-side outputs; everything quiet while reset is held.
    always_comb begin
        ihit     = 1'b0;
        imemload = 32'h0;
        iREN     = 1'b0;
        iaddr    = 32'h0;
        if (!RST) begin
            if (state_q == IDLE) begin
                ihit     = hit;
                imemload = hit ? data_q[req_idx] : 32'h0;
            end else begin
                iREN  = 1'b1;
                iaddr = miss_addr_q;
            end
        end
    end

    // Control FSM: detect a miss in IDLE, hold the request until memory answers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            miss_addr_q <= 32'h0;
            valid_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (imemREN && !hit) begin
                        miss_addr_q <= imemaddr & ~32'h3;
                        state_q     <= MISS;
                    end
                end
                MISS: begin
                    if (!iwait) begin
                        valid_q[miss_idx] <= 1'b1;
                        state_q           <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Frame tag/data storage; the occupant is simply overwritten on fill.
    always_ff @(posedge CLK) begin
        if (!RST && fill) begin
            tag_q[miss_idx]  <= miss_tag;
            data_q[miss_idx] <= iload;
        end
    end

endmodule
